// File: rtl/cmd_decode_seq.sv
// Command decoder: buffers {opcode, modifier} words in a small FIFO and issues each
// as a registered one-hot strobe, replaying burst-class opcodes for modifier+1 beats.
module cmd_decode_seq #(
  parameter int                  OP_W         = 4,
  parameter int                  MOD_W        = 4,
  parameter int                  DEPTH        = 4,
  parameter logic [2**OP_W-1:0]  ILLEGAL_MASK = '0,
  parameter int                  BURST_MSB    = 1
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [OP_W+MOD_W-1:0]  in_cmd,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2**OP_W-1:0]     out_strobe,
  output logic [MOD_W-1:0]       out_mod,
  output logic                   out_last,
  output logic                   err_illegal,
  input  logic                   clr_err,
  output logic [15:0]            cmd_count
);

  localparam int NS = 2**OP_W;
  localparam int CW = OP_W + MOD_W;
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, BURST} state_t;

  state_t              state_reg, state_next;
  logic [AW:0]         wr_ptr_reg, rd_ptr_reg, wr_ptr_next, rd_ptr_next;
  logic [AW:0]         occ, occ_next;
  logic                pushed_last_reg;
  logic                in_ready_reg;
  logic                out_valid_reg, valid_next;
  logic [NS-1:0]       strobe_reg, strobe_next;
  logic [MOD_W-1:0]    mod_reg, mod_next;
  logic                last_reg, last_next;
  logic [MOD_W-1:0]    beat_reg, beat_next;
  logic                err_reg, err_next;
  logic [15:0]         cnt_reg, cnt_next;

  logic [CW-1:0]       mem [DEPTH];
  logic [CW-1:0]       head;
  logic [OP_W-1:0]     head_op;
  logic [MOD_W-1:0]    head_mod;
  logic [NS-1:0]       dec;
  logic                head_nop, head_ill, head_burst;
  logic                push, pop, done, avail;

  assign push     = in_valid & in_ready_reg;
  assign occ      = wr_ptr_reg - rd_ptr_reg;
  // A word becomes poppable one edge after it was written, giving the two-edge latency.
  assign avail    = occ > {{AW{1'b0}}, pushed_last_reg};

  assign head     = mem[rd_ptr_reg[AW-1:0]];
  assign head_op  = head[CW-1:MOD_W];
  assign head_mod = head[MOD_W-1:0];

  generate
    for (genvar gi = 0; gi < NS; gi++) begin : g_dec
      assign dec[gi] = (head_op == OP_W'(gi));
    end
  endgenerate

  assign head_nop   = dec[0];
  assign head_ill   = |(dec & ILLEGAL_MASK);
  assign head_burst = (BURST_MSB != 0) && head_op[OP_W-1] && (head_mod != '0);

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_reg[AW-1:0]] <= in_cmd;
  end

  always_comb begin
    state_next  = state_reg;
    valid_next  = out_valid_reg;
    strobe_next = strobe_reg;
    mod_next    = mod_reg;
    last_next   = last_reg;
    beat_next   = beat_reg;
    pop         = 1'b0;
    done        = 1'b0;
    case (state_reg)
      IDLE: pop = avail;
      ISSUE: begin
        if (out_ready) begin
          done = 1'b1;
          pop  = avail;
          if (!avail) begin
            state_next  = IDLE;
            valid_next  = 1'b0;
            strobe_next = '0;
            last_next   = 1'b0;
          end
        end
      end
      BURST: begin
        if (out_ready) begin
          if (beat_reg == MOD_W'(1)) begin
            last_next  = 1'b1;
            state_next = ISSUE;
          end else begin
            beat_next = beat_reg - MOD_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
    // Popped NOP/illegal words are dropped and leave the output idle.
    if (pop) begin
      if (head_nop || head_ill) begin
        state_next  = IDLE;
        valid_next  = 1'b0;
        strobe_next = '0;
        last_next   = 1'b0;
      end else begin
        valid_next  = 1'b1;
        strobe_next = dec;
        mod_next    = head_mod;
        if (head_burst) begin
          state_next = BURST;
          beat_next  = head_mod;
          last_next  = 1'b0;
        end else begin
          state_next = ISSUE;
          last_next  = 1'b1;
        end
      end
    end
  end

  assign wr_ptr_next = wr_ptr_reg + {{AW{1'b0}}, push};
  assign rd_ptr_next = rd_ptr_reg + {{AW{1'b0}}, pop};
  assign occ_next    = wr_ptr_next - rd_ptr_next;
  assign err_next    = (pop & ~head_nop & head_ill) | (err_reg & ~clr_err);
  assign cnt_next    = cnt_reg + {15'd0, done} + {15'd0, pop & head_nop};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      pushed_last_reg <= 1'b0;
      in_ready_reg    <= 1'b1;
      out_valid_reg   <= 1'b0;
      strobe_reg      <= '0;
      mod_reg         <= '0;
      last_reg        <= 1'b0;
      beat_reg        <= '0;
      err_reg         <= 1'b0;
      cnt_reg         <= '0;
    end else begin
      state_reg       <= state_next;
      wr_ptr_reg      <= wr_ptr_next;
      rd_ptr_reg      <= rd_ptr_next;
      pushed_last_reg <= push;
      in_ready_reg    <= (occ_next != (AW+1)'(DEPTH));
      out_valid_reg   <= valid_next;
      strobe_reg      <= strobe_next;
      mod_reg         <= mod_next;
      last_reg        <= last_next;
      beat_reg        <= beat_next;
      err_reg         <= err_next;
      cnt_reg         <= cnt_next;
    end
  end

  assign in_ready    = in_ready_reg;
  assign out_valid   = out_valid_reg;
  assign out_strobe  = strobe_reg;
  assign out_mod     = mod_reg;
  assign out_last    = last_reg;
  assign err_illegal = err_reg;
  assign cmd_count   = cnt_reg;

endmodule

// File: tb/tb_cmd_decode_seq.sv
// Bench for cmd_decode_seq: directed scenarios with literal expectations, then random
// traffic compared every cycle against a queue-based behavioural model.
module tb_cmd_decode_seq;

  localparam int          DEPTH = 4;
  localparam logic [15:0] MASK  = 16'h0080;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready;
  logic [7:0]  in_cmd;
  logic        out_valid, out_ready;
  logic [15:0] out_strobe;
  logic [3:0]  out_mod;
  logic        out_last, err_illegal, clr_err;
  logic [15:0] cmd_count;

  always #5 clock = ~clock;

  cmd_decode_seq #(
    .OP_W(4), .MOD_W(4), .DEPTH(DEPTH), .ILLEGAL_MASK(MASK), .BURST_MSB(1)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd),
    .out_valid(out_valid), .out_ready(out_ready), .out_strobe(out_strobe),
    .out_mod(out_mod), .out_last(out_last), .err_illegal(err_illegal),
    .clr_err(clr_err), .cmd_count(cmd_count)
  );

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  // Behavioural model: queue of pending words with their push edge, plus current item.
  logic [7:0]  mq[$];
  int          mt[$];
  int          ecnt = 0;
  bit          m_valid;
  logic [15:0] m_strobe;
  logic [3:0]  m_mod;
  int          m_left;
  bit          m_err;
  logic [15:0] m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mt.delete();
    m_valid  = 1'b0;
    m_strobe = '0;
    m_mod    = '0;
    m_left   = 0;
    m_err    = 1'b0;
    m_cnt    = '0;
  endtask

  task automatic model_step();
    int k;
    bit push, ok, try_load, ill;
    logic [7:0] c;
    logic [3:0] op, md;
    ecnt++;
    k        = ecnt;
    ok       = 1'b0;
    ill      = 1'b0;
    try_load = 1'b0;
    push     = in_valid && (mq.size() < DEPTH);
    if (mq.size() > 0) ok = (mt[0] <= k - 2);
    if (m_valid) begin
      if (out_ready) begin
        m_left--;
        if (m_left == 0) begin
          m_cnt++;
          m_valid  = 1'b0;
          m_strobe = '0;
          try_load = 1'b1;
        end
      end
    end else begin
      try_load = 1'b1;
    end
    if (try_load && ok) begin
      c  = mq.pop_front();
      void'(mt.pop_front());
      op = c[7:4];
      md = c[3:0];
      if (op == 4'd0) m_cnt++;
      else if (MASK[op]) ill = 1'b1;
      else begin
        m_valid  = 1'b1;
        m_strobe = 16'h0001 << op;
        m_mod    = md;
        m_left   = (op[3] && md != 4'd0) ? int'(md) + 1 : 1;
      end
    end
    if (ill) m_err = 1'b1;
    else if (clr_err) m_err = 1'b0;
    if (push) begin
      mq.push_back(in_cmd);
      mt.push_back(k);
    end
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("out_strobe", 32'(out_strobe), 32'(m_strobe));
      chk("err_illegal", 32'(err_illegal), 32'(m_err));
      chk("cmd_count", 32'(cmd_count), 32'(m_cnt));
      if (m_valid) begin
        chk("out_mod", 32'(out_mod), 32'(m_mod));
        chk("out_last", 32'(out_last), 32'(m_left == 1));
      end
    end
  end

  task automatic tick(input bit iv, input logic [7:0] c, input bit ordy, input bit clr);
    in_valid  = iv;
    in_cmd    = c;
    out_ready = ordy;
    clr_err   = clr;
    @(posedge clock);
    model_step();
    @(negedge clock);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] op, md;
    int r;
    reset_n = 1'b0; in_valid = 1'b0; in_cmd = '0; out_ready = 1'b0; clr_err = 1'b0;
    model_reset();
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_strobe", 32'(out_strobe), 32'h0);
    chk("rst_out_mod", 32'(out_mod), 32'h0);
    chk("rst_out_last", 32'(out_last), 32'h0);
    chk("rst_err", 32'(err_illegal), 32'h0);
    chk("rst_cmd_count", 32'(cmd_count), 32'h0);
    @(negedge clock); #1;
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // Single command: visible two edges after the push.
    tick(1, 8'h23, 1, 0);
    tick(0, 8'h00, 1, 0);
    chk("s1_not_yet", 32'(out_valid), 32'h0);
    tick(0, 8'h00, 1, 0);
    chk("s1_valid", 32'(out_valid), 32'h1);
    chk("s1_strobe", 32'(out_strobe), 32'h0004);
    chk("s1_mod", 32'(out_mod), 32'h3);
    chk("s1_last", 32'(out_last), 32'h1);
    tick(0, 8'h00, 1, 0);
    chk("s1_done_valid", 32'(out_valid), 32'h0);
    chk("s1_count", 32'(cmd_count), 32'h1);

    // Burst of three beats with a two-cycle stall.
    tick(1, 8'hA2, 1, 0);
    tick(0, 8'h00, 1, 0);
    tick(0, 8'h00, 1, 0);
    chk("s2_b1_strobe", 32'(out_strobe), 32'h0400);
    chk("s2_b1_last", 32'(out_last), 32'h0);
    tick(0, 8'h00, 1, 0);
    chk("s2_b2_last", 32'(out_last), 32'h0);
    tick(0, 8'h00, 0, 0);
    tick(0, 8'h00, 0, 0);
    chk("s2_hold_valid", 32'(out_valid), 32'h1);
    chk("s2_hold_strobe", 32'(out_strobe), 32'h0400);
    chk("s2_hold_last", 32'(out_last), 32'h0);
    chk("s2_hold_mod", 32'(out_mod), 32'h2);
    tick(0, 8'h00, 1, 0);
    chk("s2_b3_last", 32'(out_last), 32'h1);
    chk("s2_b3_strobe", 32'(out_strobe), 32'h0400);
    tick(0, 8'h00, 1, 0);
    chk("s2_done_valid", 32'(out_valid), 32'h0);
    chk("s2_count", 32'(cmd_count), 32'h2);

    // Fill the FIFO behind a stalled command, then drain back-to-back.
    tick(1, 8'h31, 0, 0);
    tick(0, 8'h00, 0, 0);
    tick(0, 8'h00, 0, 0);
    tick(1, 8'h41, 0, 0);
    tick(1, 8'h52, 0, 0);
    tick(1, 8'h63, 0, 0);
    chk("s3_ready_3", 32'(in_ready), 32'h1);
    tick(1, 8'h14, 0, 0);
    chk("s3_full", 32'(in_ready), 32'h0);
    tick(1, 8'h25, 0, 0);
    chk("s3_still_full", 32'(in_ready), 32'h0);
    chk("s3_head_strobe", 32'(out_strobe), 32'h0008);
    tick(0, 8'h00, 1, 0);
    chk("s3_d1", 32'(out_strobe), 32'h0010);
    tick(0, 8'h00, 1, 0);
    chk("s3_d2", 32'(out_strobe), 32'h0020);
    tick(0, 8'h00, 1, 0);
    chk("s3_d3", 32'(out_strobe), 32'h0040);
    tick(0, 8'h00, 1, 0);
    chk("s3_d4", 32'(out_strobe), 32'h0002);
    chk("s3_d4_valid", 32'(out_valid), 32'h1);
    tick(0, 8'h00, 1, 0);
    chk("s3_empty_valid", 32'(out_valid), 32'h0);
    chk("s3_count", 32'(cmd_count), 32'h7);

    // Illegal opcode 7; then clear colliding with a new illegal pop.
    tick(1, 8'h71, 0, 0);
    tick(0, 8'h00, 0, 0);
    tick(0, 8'h00, 0, 0);
    chk("s4_err", 32'(err_illegal), 32'h1);
    chk("s4_valid", 32'(out_valid), 32'h0);
    chk("s4_count", 32'(cmd_count), 32'h7);
    tick(1, 8'h71, 0, 0);
    tick(0, 8'h00, 0, 0);
    tick(0, 8'h00, 0, 1);
    chk("s4_set_wins", 32'(err_illegal), 32'h1);
    tick(0, 8'h00, 0, 1);
    chk("s4_cleared", 32'(err_illegal), 32'h0);

    // NOP followed by a real command.
    tick(1, 8'h00, 1, 0);
    tick(1, 8'h15, 1, 0);
    tick(0, 8'h00, 1, 0);
    chk("s5_nop_valid", 32'(out_valid), 32'h0);
    chk("s5_nop_count", 32'(cmd_count), 32'h8);
    tick(0, 8'h00, 1, 0);
    chk("s5_strobe", 32'(out_strobe), 32'h0002);
    chk("s5_mod", 32'(out_mod), 32'h5);
    tick(0, 8'h00, 1, 0);
    chk("s5_count", 32'(cmd_count), 32'h9);

    // Asynchronous reset in the middle of a burst with two words queued.
    tick(1, 8'hF5, 0, 0);
    tick(1, 8'h21, 0, 0);
    tick(1, 8'h32, 0, 0);
    tick(0, 8'h00, 1, 0);
    chk("s6_burst_valid", 32'(out_valid), 32'h1);
    chk("s6_burst_strobe", 32'(out_strobe), 32'h8000);
    #2;
    mon_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("s6_rst_valid", 32'(out_valid), 32'h0);
    chk("s6_rst_strobe", 32'(out_strobe), 32'h0);
    model_reset();
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    reset_n = 1'b1;
    mon_en  = 1'b1;
    chk("s6_in_ready", 32'(in_ready), 32'h1);
    tick(0, 8'h00, 1, 0);
    tick(0, 8'h00, 1, 0);
    tick(0, 8'h00, 1, 0);
    chk("s6_fifo_empty", 32'(out_valid), 32'h0);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) op = 4'd0;
      else if (r == 1) op = 4'd7;
      else if (r < 5) op = 4'($urandom_range(8, 15));
      else op = 4'($urandom_range(1, 15));
      md = (r < 5) ? 4'($urandom_range(0, 3)) : 4'($urandom);
      tick(($urandom_range(0, 9) < 6), {op, md},
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0));
    end
    for (int i = 0; i < 80; i++) tick(0, 8'h00, 1, 0);
    chk("final_idle", 32'(out_valid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
